// File: rtl/counter_pkg.sv
//--------------------------------------------------------------------------
//  Module      : counter_pkg
//  Description : Shared types, constants and packing helper for the counter
//                example design.
//  Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

    localparam int COUNT_WIDTH = 8;

    typedef logic [COUNT_WIDTH-1:0] count_t;

    // Overflow is the MSB of the packed result.
    typedef struct packed {
        logic   overflow;
        count_t count;
    } counter_out_t;

    function automatic counter_out_t pack_out(input count_t count, input logic overflow);
        counter_out_t r;
        r.overflow = overflow;
        r.count    = count;
        return r;
    endfunction

endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_core.sv
//--------------------------------------------------------------------------
//  Module      : counter_core
//  Description : Enabled up-counter with wrap-around and one-cycle overflow
//                pulse; count and overflow are both registered.
//  Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

module counter_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;
    logic [WIDTH-1:0] w_count_inc;
    logic             w_at_max;

    // Increment stays in WIDTH bits; the carry is recovered from the all-ones compare.
    assign w_count_inc = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_at_max    = (r_count == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_enable) begin
            r_count    <= w_count_inc;
            r_overflow <= w_at_max;
        end else begin
            r_overflow <= 1'b0;
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule : counter_core

`default_nettype wire

// File: rtl/counter_top.sv
//--------------------------------------------------------------------------
//  Module      : counter_top
//  Description : Top-level wrapper: counter core with {overflow, count}
//                packed onto a single registered output bus.
//  Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

module counter_top
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    output logic [WIDTH:0] output__
);

    logic [WIDTH-1:0] w_count;
    logic             w_overflow;

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (enable),
        .o_count    (w_count),
        .o_overflow (w_overflow)
    );

    // The package struct only fits the default width; other widths pack directly.
    generate
        if (WIDTH == COUNT_WIDTH) begin : g_pkg_pack
            counter_out_t w_packed;
            assign w_packed = pack_out(w_count, w_overflow);
            assign output__ = w_packed;
        end else begin : g_generic_pack
            assign output__ = {w_overflow, w_count};
        end
    endgenerate

endmodule : counter_top

`default_nettype wire

// File: tb/tb_counter_top.sv
//--------------------------------------------------------------------------
//  Module      : tb_counter_top
//  Description : Self-checking bench for counter_top against a behavioural
//                model, with directed phases and randomized enable/reset.
//  Revision    : 1.0 - initial release
//--------------------------------------------------------------------------
`default_nettype none

module tb_counter_top;

    localparam int WIDTH = 8;
    localparam int MODN  = 1 << WIDTH;

    logic           clk;
    logic           rst;
    logic           enable;
    logic [WIDTH:0] output__;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_count = 0;
    bit m_ovf   = 1'b0;
    bit m_valid = 1'b0;

    counter_top #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .output__ (output__)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] model_out();
        logic [WIDTH:0] v;
        v = (m_count % MODN) + (m_ovf ? MODN : 0);
        return v;
    endfunction

    // Apply inputs for one clock edge and advance the model by the same rules.
    task automatic step(input bit r, input bit e);
        rst    = r;
        enable = e;
        @(posedge clk);
        if (r) begin
            m_count = 0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else if (e) begin
            m_ovf   = (m_count == MODN - 1);
            m_count = (m_count + 1) % MODN;
        end else begin
            m_ovf   = 1'b0;
        end
        #1;
    endtask

    task automatic steps(input int n, input bit r, input bit e);
        for (int i = 0; i < n; i++) step(r, e);
    endtask

    task automatic check_lit(input string name, input logic [WIDTH:0] exp);
        checks++;
        if (output__ !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, output__, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (output__ !== model_out()) begin
                errors++;
                $display("FAIL model_cmp: got %h expected %h at %0t", output__, model_out(), $time);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;

        // Reset hold
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            check_lit("reset_hold", 9'h000);
        end

        // Idle, then enabled counting
        steps(5, 1'b0, 1'b0);
        check_lit("idle_after_reset", 9'h000);
        steps(20, 1'b0, 1'b1);
        check_lit("count_20", 9'h014);

        // Disable hold and re-enable
        steps(5, 1'b0, 1'b0);
        check_lit("hold_20", 9'h014);
        steps(10, 1'b0, 1'b1);
        check_lit("count_30", 9'h01e);

        // Wrap / overflow
        steps(225, 1'b0, 1'b1);
        check_lit("reach_max", 9'h0ff);
        step(1'b0, 1'b1);
        check_lit("wrap_pulse", 9'h100);
        step(1'b0, 1'b1);
        check_lit("after_wrap", 9'h001);
        steps(3, 1'b0, 1'b1);
        check_lit("ovf_stays_low", 9'h004);

        // Reset mid-count has priority over enable
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check_lit("reset_priority", 9'h000);
        end
        steps(10, 1'b0, 1'b1);
        check_lit("count_10_after_reset", 9'h00a);

        // Disable at max, then wrap
        steps(245, 1'b0, 1'b1);
        check_lit("max_again", 9'h0ff);
        steps(4, 1'b0, 1'b0);
        check_lit("hold_at_max", 9'h0ff);
        step(1'b0, 1'b1);
        check_lit("wrap_after_hold", 9'h100);
        step(1'b0, 1'b0);
        check_lit("hold_clears_ovf", 9'h000);

        // Randomized enable with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_counter_top

`default_nettype wire
